// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the core's single memory port between instruction fetch (if_*) and
//   the load/store unit (lsu_*). Only one transaction is outstanding at a time:
//   address phase (req/gnt), then response phase (rvalid). LSU has fixed
//   priority over fetch. A starvation counter forces fetch to win after
//   STARVE_MAX consecutive LSU grants taken while fetch was waiting.
// Ports:
//   clk, arst_n         clock, asynchronous active-low reset
//   if_req/addr         fetch address phase in; if_gnt/if_rvalid/if_rdata out
//   lsu_req/we/be/addr/wdata  LSU address phase in; lsu_gnt/rvalid/rdata out
//   mem_req/we/be/addr/wdata  memory address phase out; mem_gnt/rvalid/rdata in
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                arst_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                lsu_req,
  input  logic                lsu_we,
  input  logic [DATA_W/8-1:0] lsu_be,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic [DATA_W-1:0]   lsu_wdata,
  output logic                lsu_gnt,
  output logic                lsu_rvalid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  logic             owner_lsu;  // 0 = fetch owns the port, 1 = LSU
  logic [CNT_W-1:0] cnt;

  logic win_lsu;
  logic sel_lsu;
  logic accept;
  logic resp_ok;

  // Fetch wins only when the LSU is idle or fetch has been starved long enough.
  assign win_lsu = lsu_req && !(if_req && (cnt == CNT_MAX));

  // In IDLE the live arbitration result steers the port; afterwards the
  // latched owner does, so a stalled address phase never re-arbitrates.
  assign sel_lsu = (state == IDLE) ? win_lsu : owner_lsu;

  always_comb begin
    mem_req = 1'b0;
    if (arst_n) begin
      unique case (state)
        IDLE:    mem_req = if_req | lsu_req;
        ADDR:    mem_req = 1'b1;
        default: mem_req = 1'b0;
      endcase
    end
  end

  assign mem_we    = sel_lsu ? lsu_we    : 1'b0;
  assign mem_be    = sel_lsu ? lsu_be    : '1;
  assign mem_addr  = sel_lsu ? lsu_addr  : if_addr;
  assign mem_wdata = sel_lsu ? lsu_wdata : '0;

  assign accept  = mem_req && mem_gnt;
  assign if_gnt  = accept && !sel_lsu;
  assign lsu_gnt = accept &&  sel_lsu;

  // Responses are only forwarded while a transaction is actually pending.
  assign resp_ok    = arst_n && (state == RESP) && mem_rvalid;
  assign if_rvalid  = resp_ok && !owner_lsu;
  assign lsu_rvalid = resp_ok &&  owner_lsu;

  assign if_rdata  = mem_rdata;
  assign lsu_rdata = mem_rdata;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state     <= IDLE;
      owner_lsu <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (if_req || lsu_req) begin
            owner_lsu <= win_lsu;
            state     <= mem_gnt ? RESP : ADDR;
          end
        end
        ADDR: if (mem_gnt)    state <= RESP;
        RESP: if (mem_rvalid) state <= IDLE;
        default:              state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cnt <= '0;
    end else if (accept) begin
      if (sel_lsu && if_req)
        cnt <= (cnt == CNT_MAX) ? CNT_MAX : cnt + CNT_W'(1);
      else
        cnt <= '0;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (STARVE_MAX = 4).
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_mem_port_arbiter;

  logic        clk;
  logic        arst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        lsu_req, lsu_we;
  logic [3:0]  lsu_be;
  logic [31:0] lsu_addr, lsu_wdata;
  logic        lsu_gnt, lsu_rvalid;
  logic [31:0] lsu_rdata;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  int unsigned tests  = 0;
  int unsigned failed = 0;

  mem_port_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .STARVE_MAX (4)
  ) dut (
    .clk        (clk),
    .arst_n     (arst_n),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_gnt     (if_gnt),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .lsu_req    (lsu_req),
    .lsu_we     (lsu_we),
    .lsu_be     (lsu_be),
    .lsu_addr   (lsu_addr),
    .lsu_wdata  (lsu_wdata),
    .lsu_gnt    (lsu_gnt),
    .lsu_rvalid (lsu_rvalid),
    .lsu_rdata  (lsu_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One back-to-back transaction: address phase accepted immediately,
  // response on the following cycle. exp_lsu selects the expected winner.
  task automatic xact(input logic ireq, input logic lreq, input logic exp_lsu,
                      input string tag);
    @(negedge clk);
    if_req = ireq; lsu_req = lreq; mem_gnt = 1'b1; mem_rvalid = 1'b0;
    #1;
    chk({tag, "_lsu_gnt"}, 64'(lsu_gnt), 64'(exp_lsu));
    chk({tag, "_if_gnt"},  64'(if_gnt),  64'(!exp_lsu));
    @(negedge clk);
    mem_rvalid = 1'b1; mem_rdata = 32'hA5A5_0001;
    #1;
    chk({tag, "_resp_mem_req"},   64'(mem_req),    64'd0);
    chk({tag, "_resp_gnt"},       64'(if_gnt | lsu_gnt), 64'd0);
    chk({tag, "_lsu_rvalid"},     64'(lsu_rvalid), 64'(exp_lsu));
    chk({tag, "_if_rvalid"},      64'(if_rvalid),  64'(!exp_lsu));
  endtask

  initial begin
    arst_n = 1'b0;
    if_req = 1'b1; if_addr = 32'h0;
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_be = 4'h0; lsu_addr = 32'h0; lsu_wdata = 32'h0;
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h0;

    // Reset: handshake outputs forced low even with all inputs active
    @(negedge clk); #1;
    chk("rst_mem_req",    64'(mem_req),    64'd0);
    chk("rst_gnt",        64'(if_gnt | lsu_gnt), 64'd0);
    chk("rst_rvalid",     64'(if_rvalid | lsu_rvalid), 64'd0);
    @(negedge clk);
    arst_n = 1'b1; if_req = 1'b0; lsu_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;

    // Single fetch
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h100; mem_gnt = 1'b1;
    #1;
    chk("f_mem_req",  64'(mem_req),  64'd1);
    chk("f_mem_addr", 64'(mem_addr), 64'h100);
    chk("f_mem_we",   64'(mem_we),   64'd0);
    chk("f_mem_be",   64'(mem_be),   64'hF);
    chk("f_mem_wdata",64'(mem_wdata),64'h0);
    chk("f_if_gnt",   64'(if_gnt),   64'd1);
    chk("f_lsu_gnt",  64'(lsu_gnt),  64'd0);
    @(negedge clk);
    if_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0013;
    #1;
    chk("f_if_rvalid", 64'(if_rvalid), 64'd1);
    chk("f_if_rdata",  64'(if_rdata),  64'h13);
    chk("f_lsu_rvalid",64'(lsu_rvalid),64'd0);
    @(negedge clk);
    mem_rvalid = 1'b0;

    // Contention: four LSU grants, then fetch forced through, repeating
    for (int i = 0; i < 10; i++)
      xact(1'b1, 1'b1, (i % 5) != 4, $sformatf("cont%0d", i));

    // LSU-alone grant clears the starvation count
    xact(1'b1, 1'b1, 1'b1, "clr_a");
    xact(1'b1, 1'b1, 1'b1, "clr_b");
    xact(1'b0, 1'b1, 1'b1, "clr_alone");
    for (int i = 0; i < 5; i++)
      xact(1'b1, 1'b1, i != 4, $sformatf("clr_cont%0d", i));

    // Stalled LSU store; fetch rises meanwhile and must not steal the port
    @(negedge clk);
    if_req = 1'b0; lsu_req = 1'b1; lsu_we = 1'b1; lsu_addr = 32'h2000;
    lsu_be = 4'h3; lsu_wdata = 32'hDEAD_BEEF; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) begin
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h300;
        mem_gnt = (c == 3);
      end
      #1;
      chk($sformatf("st%0d_mem_req", c),  64'(mem_req),   64'd1);
      chk($sformatf("st%0d_mem_addr", c), 64'(mem_addr),  64'h2000);
      chk($sformatf("st%0d_mem_be", c),   64'(mem_be),    64'h3);
      chk($sformatf("st%0d_mem_wdata", c),64'(mem_wdata), 64'hDEAD_BEEF);
      chk($sformatf("st%0d_mem_we", c),   64'(mem_we),    64'd1);
      chk($sformatf("st%0d_if_gnt", c),   64'(if_gnt),    64'd0);
      chk($sformatf("st%0d_lsu_gnt", c),  64'(lsu_gnt),   64'(c == 3));
    end
    @(negedge clk);
    lsu_req = 1'b0; lsu_we = 1'b0; mem_gnt = 1'b1; mem_rvalid = 1'b1;
    #1;
    chk("st_lsu_rvalid", 64'(lsu_rvalid), 64'd1);
    chk("st_if_rvalid",  64'(if_rvalid),  64'd0);
    chk("st_resp_req",   64'(mem_req),    64'd0);
    @(negedge clk);
    mem_rvalid = 1'b0;
    #1;
    chk("st_next_if_gnt", 64'(if_gnt), 64'd1);
    chk("st_next_addr",   64'(mem_addr), 64'h300);
    chk("st_next_be",     64'(mem_be),   64'hF);
    @(negedge clk);
    if_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1;
    #1;
    chk("st_next_rvalid", 64'(if_rvalid), 64'd1);
    @(negedge clk);
    mem_rvalid = 1'b0;

    // Reset while waiting for a response; late rvalid must be dropped
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h400; mem_gnt = 1'b1;
    #1;
    chk("rr_if_gnt", 64'(if_gnt), 64'd1);
    @(negedge clk);
    if_req = 1'b0; mem_gnt = 1'b0;
    arst_n = 1'b0;
    #1;
    mem_rvalid = 1'b1;
    #1;
    chk("rr_in_rst_rvalid", 64'(if_rvalid | lsu_rvalid), 64'd0);
    mem_rvalid = 1'b0;
    @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b1;
    #1;
    chk("rr_late_if_rvalid",  64'(if_rvalid),  64'd0);
    chk("rr_late_lsu_rvalid", 64'(lsu_rvalid), 64'd0);
    chk("rr_late_mem_req",    64'(mem_req),    64'd0);
    @(negedge clk);
    mem_rvalid = 1'b0; if_req = 1'b1; if_addr = 32'h500; mem_gnt = 1'b1;
    #1;
    chk("rr_next_if_gnt", 64'(if_gnt),   64'd1);
    chk("rr_next_addr",   64'(mem_addr), 64'h500);
    @(negedge clk);
    if_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    #1;
    chk("rr_next_rvalid", 64'(if_rvalid), 64'd1);
    chk("rr_next_rdata",  64'(if_rdata),  64'h1234_5678);

    // Spurious rvalid in IDLE: ignored, state stays IDLE
    @(negedge clk);
    mem_rvalid = 1'b1;
    #1;
    chk("sp_rvalid", 64'(if_rvalid | lsu_rvalid), 64'd0);
    @(negedge clk);
    mem_rvalid = 1'b0; lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h600; mem_gnt = 1'b1;
    #1;
    chk("sp_next_mem_req", 64'(mem_req), 64'd1);
    chk("sp_next_lsu_gnt", 64'(lsu_gnt), 64'd1);
    @(negedge clk);
    lsu_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1;
    #1;
    chk("sp_next_lsu_rvalid", 64'(lsu_rvalid), 64'd1);
    @(negedge clk);
    mem_rvalid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
